// File: rtl/iq_tone_gen_if.sv
// Control and sample bus of the IQ test-tone transmitter.
// The MCU/start FSM (or a testbench) drives it through master; the generator uses slave.
interface iq_tone_gen_if;
    logic               start;
    logic               stop;
    logic [15:0]        burst_len;
    logic [3:0]         phase_step;
    logic [3:0]         div;
    logic signed [12:0] Gr_inj;
    logic signed [12:0] Gj_inj;
    logic [3:0]         Ix;
    logic [3:0]         Qx;
    logic               valid;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, burst_len, phase_step, div, Gr_inj, Gj_inj,
        input  Ix, Qx, valid, busy, done
    );

    modport slave (
        input  start, stop, burst_len, phase_step, div, Gr_inj, Gj_inj,
        output Ix, Qx, valid, busy, done
    );
endinterface

// File: rtl/iq_tone_gen.sv
// Quadrature tone burst generator with injected W-style gain/phase imbalance,
// producing 4-bit offset-binary Ix/Qx like the ADC front end.
module iq_tone_gen (
    input  logic         clk,
    input  logic         RESET,
    iq_tone_gen_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e             state_q, state_d;

    logic [15:0]        cfgLen_q;
    logic [3:0]         cfgStep_q;
    logic [3:0]         cfgDiv_q;
    logic signed [12:0] cfgGr_q;
    logic signed [12:0] cfgGj_q;

    logic [3:0]         phase_q;
    logic [15:0]        sampleCount_q;
    logic [3:0]         divCount_q;

    logic signed [3:0]  stage1I_q;
    logic signed [3:0]  stage1Q_q;
    logic               stage1Valid_q;
    logic               stage1Last_q;

    logic [3:0]         outI_q;
    logic [3:0]         outQ_q;
    logic               outValid_q;
    logic               outDone_q;

    logic               accept;
    logic               abort;
    logic               tick;
    logic               lastTick;

    logic signed [17:0] iWide, qWide, grWide, gjWide;
    logic signed [17:0] accI, accQ;
    logic signed [9:0]  sumI, sumQ;

    function automatic logic signed [3:0] toneLut(input logic [3:0] k);
        logic signed [3:0] c;
        case (k)
            4'd0:    c = 4'sd7;
            4'd1:    c = 4'sd6;
            4'd2:    c = 4'sd5;
            4'd3:    c = 4'sd3;
            4'd4:    c = 4'sd0;
            4'd5:    c = -4'sd3;
            4'd6:    c = -4'sd5;
            4'd7:    c = -4'sd6;
            4'd8:    c = -4'sd7;
            4'd9:    c = -4'sd6;
            4'd10:   c = -4'sd5;
            4'd11:   c = -4'sd3;
            4'd12:   c = 4'sd0;
            4'd13:   c = 4'sd3;
            4'd14:   c = 4'sd5;
            default: c = 4'sd6;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] toOffsetBinary(input logic signed [9:0] v);
        logic [3:0] s;
        if (v > 10'sd7) begin
            s = 4'b0111;
        end else if (v < -10'sd8) begin
            s = 4'b1000;
        end else begin
            s = v[3:0];
        end
        return {~s[3], s[2:0]};
    endfunction

    assign accept   = (state_q == IDLE) && bus.start && !bus.stop;
    assign abort    = (state_q != IDLE) && bus.stop;
    assign tick     = (state_q == RUN) && (divCount_q == 4'd0);
    // A zero burst length means continuous, so it never produces a last tick.
    assign lastTick = tick && (cfgLen_q != 16'd0) && ((sampleCount_q + 16'd1) == cfgLen_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (bus.stop) state_d = IDLE;
                     else if (lastTick) state_d = DRAIN;
            DRAIN:   if (bus.stop || !stage1Valid_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Products are kept at full precision before the floor shift by 9.
    always_comb begin
        iWide  = 18'(stage1I_q);
        qWide  = 18'(stage1Q_q);
        grWide = 18'(cfgGr_q);
        gjWide = 18'(cfgGj_q);
        accI   = grWide * iWide + gjWide * qWide;
        accQ   = gjWide * iWide - grWide * qWide;
        sumI   = 10'(iWide) + 10'(accI >>> 9);
        sumQ   = 10'(qWide) + 10'(accQ >>> 9);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q       <= IDLE;
            cfgLen_q      <= '0;
            cfgStep_q     <= '0;
            cfgDiv_q      <= '0;
            cfgGr_q       <= '0;
            cfgGj_q       <= '0;
            phase_q       <= '0;
            sampleCount_q <= '0;
            divCount_q    <= '0;
            stage1I_q     <= '0;
            stage1Q_q     <= '0;
            stage1Valid_q <= 1'b0;
            stage1Last_q  <= 1'b0;
            outI_q        <= 4'd8;
            outQ_q        <= 4'd8;
            outValid_q    <= 1'b0;
            outDone_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                cfgLen_q      <= bus.burst_len;
                cfgStep_q     <= bus.phase_step;
                cfgDiv_q      <= bus.div;
                cfgGr_q       <= bus.Gr_inj;
                cfgGj_q       <= bus.Gj_inj;
                phase_q       <= '0;
                sampleCount_q <= '0;
                divCount_q    <= '0;
            end else if (tick) begin
                phase_q       <= phase_q + cfgStep_q;
                sampleCount_q <= sampleCount_q + 16'd1;
                divCount_q    <= cfgDiv_q;
            end else if (state_q == RUN) begin
                divCount_q    <= divCount_q - 4'd1;
            end

            if (abort) begin
                stage1Valid_q <= 1'b0;
                stage1Last_q  <= 1'b0;
            end else begin
                stage1Valid_q <= tick;
                stage1Last_q  <= lastTick;
                if (tick) begin
                    stage1I_q <= toneLut(phase_q);
                    stage1Q_q <= toneLut(phase_q - 4'd4);
                end
            end

            // Outputs park at mid-scale whenever the generator goes idle.
            if (abort || (state_d == IDLE && !stage1Valid_q)) begin
                outI_q     <= 4'd8;
                outQ_q     <= 4'd8;
                outValid_q <= 1'b0;
                outDone_q  <= 1'b0;
            end else if (stage1Valid_q) begin
                outI_q     <= toOffsetBinary(sumI);
                outQ_q     <= toOffsetBinary(sumQ);
                outValid_q <= 1'b1;
                outDone_q  <= stage1Last_q;
            end else begin
                outValid_q <= 1'b0;
                outDone_q  <= 1'b0;
            end
        end
    end

    assign bus.Ix    = outI_q;
    assign bus.Qx    = outQ_q;
    assign bus.valid = outValid_q;
    assign bus.done  = outDone_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: doc/iq_tone_gen.md
# iq_tone_gen

Test-stimulus transmitter for the IQ compensation path: generates a quadrature tone, applies a programmable gain/phase imbalance with the same W-style coefficient model the compensator removes, and drives 4-bit offset-binary Ix/Qx exactly as the ADC front end does. Sits in front of the compensator in bring-up and in the verification harness, so a known imbalance can be injected and the compensator's convergence measured. Bursts are started and stopped by the MCU/start FSM through a start/stop/busy/done handshake.

## Interface
- No parameters; all widths fixed.
- clk  in  1  sole clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; honoured only when idle.
- stop  in  1  abort; honoured when busy.
- burst_len  in  16  samples per burst; 0 = continuous until stop.
- phase_step  in  4  phase increment per sample (16 phases/cycle).
- div  in  4  sample period = div+1 clk cycles.
- Gr_inj, Gj_inj  in  13 signed  imbalance coefficients, scale 1/512.
- Ix, Qx  out  4  offset-binary samples (8 = zero).
- valid  out  1  high one cycle per new Ix/Qx.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on last sample of a finite burst.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 and stop=0 -> latch burst_len, phase_step, div, Gr_inj, Gj_inj; phase accumulator <= 0; sample counter <= 0; divider counter <= 0; go RUN. start with stop=1 -> stay IDLE.
- RUN: tick when divider counter = 0, then reload div; otherwise decrement. On tick: phase <= phase + step (mod 16), counter +1. Finite burst: tick producing sample burst_len -> DRAIN. burst_len = 0: never leaves RUN on count.
- DRAIN: wait until pipeline empty, then IDLE.
- stop in RUN or DRAIN -> IDLE next edge; in-flight samples discarded (no valid, no done). start while busy ignored; latched config unaffected by input changes while busy.
- Tone LUT C[k], k=0..15: 7,6,5,3,0,-3,-5,-6,-7,-6,-5,-3,0,3,5,6. Is = C[phase], Qs = C[(phase-4) mod 16].
- Imbalance: I' = Is + ((Gr*Is + Gj*Qs) >>> 9); Q' = Qs + ((Gj*Is - Gr*Qs) >>> 9). Products full precision (≥18-bit sum), arithmetic shift = floor toward -inf, result saturated to [-8, 7].
- Output: Ix = I' + 8, Qx = Q' + 8 (4-bit, i.e. MSB inverted).
- Pipeline: stage 1 registers Is/Qs on tick; stage 2 registers Ix/Qx/valid.

## Timing
- Reset values: state IDLE, Ix=Qx=8, valid=0, busy=0, done=0, all counters/pipeline 0.
- start sampled at edge t: busy=1 from edge t; first tick in cycle after t; first valid=1 from edge t+2; subsequent valids every div+1 cycles.
- Ix/Qx hold last value between valids; return to 8 at edge when IDLE is re-entered (abort or completion).
- done=1 in the same cycle as the last valid; busy falls at the next edge (busy and done overlap one cycle). No done for continuous bursts or aborts.
- Abort at edge s: busy=0, valid=0, Ix=Qx=8 from edge s; pipeline flushed.
- RESET mid-burst: identical to reset values at the next edge, no done.
- Back-to-back: start accepted the cycle after busy falls.

## Test plan
- Gr=Gj=0, step=4, div=0, len=4, start at t -> valid at t+2..t+5; Ix 15,8,1,8; Qx 8,15,8,1; done with 4th valid; busy low at t+6.
- Gr=512, Gj=0, same tone -> Ix 15,8,0,8 (saturated both ends); Qx 8,8,8,8.
- Gr=0, Gj=512, step=2, len=2 -> Ix/Qx = 15/15, 15/15 (second sample saturates from 10).
- div=2, len=3 -> valid at t+2, t+5, t+8 only; done at t+8; start pulses at t+4 ignored, no config change.
- len=0, step=1 -> valid every cycle, Ix cycles through 16 LUT values +8 indefinitely; stop at edge s -> valid=0, Ix=Qx=8, busy=0 from s, no done.
- RESET asserted mid-burst, then start -> all outputs at reset values; new burst's first sample uses phase 0.
